// File: rtl/access_ctrl_fsm.sv
// Access-control sequencer: collects a user ID and then a password from keypad codes and drives
// the LCD message select, door and alarm. Define MASK_DIGITS_EN to show password digits as '*'.
module access_ctrl_fsm #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter logic [15:0] USER_ID     = 16'h1234,
    parameter logic [15:0] PASSWORD    = 16'h4321,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned OPEN_CYCLES = 250_000_000,
    parameter int unsigned LOCK_CYCLES = 500_000_000,
    parameter int unsigned CHG_HOLD    = 1_700_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [1:0] sel_msg,
    output logic       message_change,
    output logic       ready_o,
    output logic [7:0] digit_o,
    output logic       door_open,
    output logic       alarm,
    output logic [1:0] tries_o
);

    localparam logic [1:0] S_USER     = 2'b00;
    localparam logic [1:0] S_PASS     = 2'b01;
    localparam logic [1:0] S_OPEN     = 2'b10;
    localparam logic [1:0] S_INTRUDER = 2'b11;

    localparam logic [3:0] KEY_CLEAR = 4'd10;
    localparam logic [3:0] KEY_ENTER = 4'd11;
    localparam logic [7:0] NO_KEY    = 8'd15;

    localparam int unsigned MAX_TIME = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int unsigned TW       = (MAX_TIME > 1) ? $clog2(MAX_TIME) : 1;
    localparam int unsigned HW       = (CHG_HOLD > 0) ? $clog2(CHG_HOLD + 1) : 1;

    localparam logic [15:0] CMP_MASK = 16'hFFFF >> (16 - 4 * NUM_DIGITS);
    localparam logic [2:0]  CNT_FULL = 3'(NUM_DIGITS);
    localparam logic [1:0]  TRY_MAX  = 2'(MAX_TRIES);
    localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(CHG_HOLD);

    logic [1:0]    r_state;
    logic [15:0]   r_buf;
    logic [2:0]    r_cnt;
    logic [1:0]    r_tries;
    logic [TW-1:0] r_timer;
    logic [HW-1:0] r_hold;
    logic [7:0]    r_digit;
    logic          r_ready;

    logic [1:0]    w_state_n;
    logic [15:0]   w_buf_n;
    logic [2:0]    w_cnt_n;
    logic [1:0]    w_tries_n;
    logic [7:0]    w_digit_n;
    logic          w_enter;
    logic          w_is_digit;
    logic          w_full;
    logic          w_expired;
    logic          w_user_ok;
    logic          w_pass_ok;

    assign w_is_digit = (key_code <= 4'd9);
    assign w_full     = (r_cnt == CNT_FULL);
    assign w_user_ok  = ((r_buf & CMP_MASK) == (USER_ID & CMP_MASK));
    assign w_pass_ok  = ((r_buf & CMP_MASK) == (PASSWORD & CMP_MASK));
    assign w_expired  = ((r_state == S_OPEN) && (r_timer == OPEN_LAST)) ||
                        ((r_state == S_INTRUDER) && (r_timer == LOCK_LAST));

    always_comb begin
        w_state_n = r_state;
        w_buf_n   = r_buf;
        w_cnt_n   = r_cnt;
        w_tries_n = r_tries;
        w_digit_n = NO_KEY;
        w_enter   = 1'b0;
        case (r_state)
            S_USER, S_PASS: begin
                if (key_valid) begin
                    if (w_is_digit) begin
                        if (!w_full) begin
                            w_buf_n = {r_buf[11:0], key_code};
                            w_cnt_n = r_cnt + 3'd1;
`ifdef MASK_DIGITS_EN
                            // LCD adds 8'h30 and wraps 8'hFA to '*'
                            w_digit_n = (r_state == S_PASS) ? 8'hFA : {4'd0, key_code};
`else
                            w_digit_n = {4'd0, key_code};
`endif
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        w_buf_n = 16'd0;
                        w_cnt_n = 3'd0;
                    end else if ((key_code == KEY_ENTER) && w_full) begin
                        w_buf_n = 16'd0;
                        w_cnt_n = 3'd0;
                        w_enter = 1'b1;
                        if (r_state == S_USER) begin
                            w_state_n = w_user_ok ? S_PASS : S_USER;
                        end else if (w_pass_ok) begin
                            w_state_n = S_OPEN;
                            w_tries_n = 2'd0;
                        end else begin
                            w_tries_n = r_tries + 2'd1;
                            w_state_n = (w_tries_n == TRY_MAX) ? S_INTRUDER : S_USER;
                        end
                    end
                end
            end
            S_OPEN: begin
                if (w_expired) begin
                    w_state_n = S_USER;
                    w_enter   = 1'b1;
                end
            end
            S_INTRUDER: begin
                if (w_expired) begin
                    w_state_n = S_USER;
                    w_tries_n = 2'd0;
                    w_enter   = 1'b1;
                end
            end
            default: begin
                w_state_n = S_USER;
                w_enter   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_USER;
            r_buf   <= 16'd0;
            r_cnt   <= 3'd0;
            r_tries <= 2'd0;
            r_timer <= '0;
            r_hold  <= '0;
            r_digit <= NO_KEY;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_buf   <= w_buf_n;
            r_cnt   <= w_cnt_n;
            r_tries <= w_tries_n;
            r_digit <= w_digit_n;
            r_ready <= 1'b1;
            if (w_enter) begin
                r_timer <= '0;
                r_hold  <= HOLD_LOAD;
            end else begin
                if ((r_state == S_OPEN) || (r_state == S_INTRUDER)) begin
                    r_timer <= r_timer + TW'(1);
                end
                if (r_hold != '0) begin
                    r_hold <= r_hold - HW'(1);
                end
            end
        end
    end

    assign sel_msg        = r_state;
    assign message_change = (r_hold != '0);
    assign ready_o        = r_ready;
    assign digit_o        = r_digit;
    assign door_open      = (r_state == S_OPEN);
    assign alarm          = (r_state == S_INTRUDER);
    assign tries_o        = r_tries;

endmodule
